// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot-load controller.
package uart_boot_pkg;
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } boot_state_e;

    localparam int HDR_BYTES = 4;
    localparam int WORD_W    = 32;
endpackage

// File: rtl/uart_boot_ctrl_if.sv
// Instruction-RAM write port: req held until gnt, transfer on req&gnt.
interface uart_boot_ctrl_if;
    import uart_boot_pkg::*;

    logic              mem_req_o;
    logic              mem_gnt_i;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [WORD_W-1:0] mem_addr_o;
    logic [WORD_W-1:0] mem_wdata_o;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte strobe.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic       o_byte_vld,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_BITS, S_STOP} rx_state_e;

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_e     r_state, w_state_next;
    logic [1:0]    r_sync;
    logic          r_rx_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_vld;
    logic          r_ferr;
    logic          w_rx, w_half, w_full;

    assign w_rx   = r_sync[1];
    assign w_half = (r_cnt == HALF);
    assign w_full = (r_cnt == FULL);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_rx && r_rx_d) w_state_next = S_START;
            // Start bit must still be low at its centre, otherwise it was a glitch.
            S_START: if (w_half) w_state_next = w_rx ? S_IDLE : S_BITS;
            S_BITS:  if (w_full && r_bit == 3'd7) w_state_next = S_STOP;
            S_STOP:  if (w_full) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_vld   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], uart_rx_i};
            r_rx_d <= w_rx;
            r_vld  <= 1'b0;
            if (r_state == S_IDLE || w_state_next != r_state || w_full) r_cnt <= '0;
            else                                                        r_cnt <= r_cnt + 1'b1;
            if (r_state == S_BITS && w_full) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == S_STOP && w_full) begin
                r_vld  <= 1'b1;
                r_ferr <= !w_rx;
            end
        end
    end

    always_comb begin
        o_byte_vld  = r_vld;
        o_byte      = r_shift;
        o_frame_err = r_vld & r_ferr;
    end
endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot loader: reads a word-count header over UART, then writes that many words to RAM.
module uart_boot_ctrl
    import uart_boot_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 87,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    uart_rx_i,
    uart_boot_ctrl_if.master        mem,
    output logic                    core_hold_o,
    output logic                    boot_done_o,
    output logic                    boot_err_o,
    output logic [15:0]             words_o
);
    localparam logic [WORD_W-1:0] MAXW = WORD_W'(MAX_WORDS);

    boot_state_e       r_state, w_state_next;
    logic [1:0]        r_lane;
    logic [WORD_W-1:0] r_asm;
    logic [15:0]       r_n, r_words, r_issued;
    logic              r_req;
    logic [WORD_W-1:0] r_addr, r_wdata;

    logic              w_byte_vld, w_frame_err;
    logic [7:0]        w_byte;
    logic [WORD_W-1:0] w_shifted;
    logic              w_good_byte, w_last_byte, w_word_done, w_xfer, w_overflow, w_final;

    uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .uart_rx_i   (uart_rx_i),
        .o_byte_vld  (w_byte_vld),
        .o_byte      (w_byte),
        .o_frame_err (w_frame_err)
    );

    // Bytes arrive little-endian, so shifting right leaves byte0 in bits 7:0.
    assign w_shifted   = {w_byte, r_asm[WORD_W-1:8]};
    assign w_good_byte = w_byte_vld && !w_frame_err;
    assign w_last_byte = w_good_byte && (r_lane == 2'(HDR_BYTES - 1));
    // Words beyond the header count are not buffered.
    assign w_word_done = (r_state == DATA) && w_last_byte && (r_issued != r_n);
    assign w_xfer      = r_req && mem.mem_gnt_i;
    assign w_overflow  = w_word_done && r_req && !mem.mem_gnt_i;
    assign w_final     = w_xfer && (r_words + 16'd1 == r_n);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= HDR;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HDR: begin
                if (w_byte_vld && w_frame_err) w_state_next = ERR;
                else if (w_last_byte) begin
                    if (w_shifted == '0)       w_state_next = DONE;
                    else if (w_shifted > MAXW) w_state_next = ERR;
                    else                       w_state_next = DATA;
                end
            end
            DATA: begin
                if ((w_byte_vld && w_frame_err) || w_overflow) w_state_next = ERR;
                else if (w_final)                              w_state_next = DONE;
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lane   <= '0;
            r_asm    <= '0;
            r_n      <= '0;
            r_words  <= '0;
            r_issued <= '0;
            r_req    <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= '0;
        end else begin
            if (w_good_byte && (r_state == HDR || r_state == DATA)) begin
                r_lane <= r_lane + 2'd1;
                r_asm  <= w_shifted;
            end
            if (r_state == HDR && w_last_byte) r_n <= w_shifted[15:0];
            // A grant in the same cycle as a new word keeps req high with fresh data.
            if (w_state_next == ERR) r_req <= 1'b0;
            else if (w_word_done) begin
                r_req    <= 1'b1;
                r_wdata  <= w_shifted;
                r_issued <= r_issued + 16'd1;
            end else if (w_xfer) r_req <= 1'b0;
            if (w_xfer) begin
                r_words <= r_words + 16'd1;
                r_addr  <= r_addr + 32'd4;
            end
        end
    end

    always_comb begin
        core_hold_o     = (r_state != DONE);
        boot_done_o     = (r_state == DONE);
        boot_err_o      = (r_state == ERR);
        words_o         = r_words;
        mem.mem_req_o   = r_req;
        mem.mem_we_o    = 1'b1;
        mem.mem_be_o    = 4'hF;
        mem.mem_addr_o  = r_addr;
        mem.mem_wdata_o = r_wdata;
    end
endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Scoreboard bench for uart_boot_ctrl: serial stimulus, expected RAM writes queued and popped on grant.
module tb_uart_boot_ctrl;
    localparam int          CPB  = 48;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          MAXW = 4096;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        gnt = 1'b0;
    bit          gnt_rand = 1'b0;
    logic        core_hold, boot_done, boot_err;
    logic [15:0] words;
    wr_t         exp_q[$];
    int          tests = 0;
    int          failed = 0;

    uart_boot_ctrl_if mem_if();
    assign mem_if.mem_gnt_i = gnt;

    uart_boot_ctrl #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uart_rx_i   (rx),
        .mem         (mem_if),
        .core_hold_o (core_hold),
        .boot_done_o (boot_done),
        .boot_err_o  (boot_err),
        .words_o     (words)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        if (gnt_rand) gnt = 1'($urandom_range(0, 1));
    end

    // Monitor: every completed transfer must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && mem_if.mem_req_o && gnt) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL write: unexpected write addr=%h data=%h, none required", mem_if.mem_addr_o, mem_if.mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (mem_if.mem_addr_o !== e.addr || mem_if.mem_wdata_o !== e.data ||
                    mem_if.mem_we_o !== 1'b1 || mem_if.mem_be_o !== 4'hF) begin
                    failed++;
                    $display("FAIL write: got addr=%h data=%h we=%b be=%h, required addr=%h data=%h we=1 be=f",
                             mem_if.mem_addr_o, mem_if.mem_wdata_o, mem_if.mem_we_o, mem_if.mem_be_o, e.addr, e.data);
                end else
                    $display("[TB] write addr=%h data=%h ok", e.addr, e.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(2);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    // Reference model: a load of n words writes word i to BASE + 4*i.
    task automatic push_wr(input int idx, input logic [31:0] data);
        wr_t e;
        e.addr = BASE + 32'(4 * idx);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx = 1'b1;
        gnt_rand = 1'b0;
        gnt = 1'b0;
        exp_q.delete();
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic check_reset(input string name);
        chk({name, ".req"}, 32'(mem_if.mem_req_o), 32'd0);
        chk({name, ".addr"}, mem_if.mem_addr_o, BASE);
        chk({name, ".wdata"}, mem_if.mem_wdata_o, 32'd0);
        chk({name, ".hold"}, 32'(core_hold), 32'd1);
        chk({name, ".done"}, 32'(boot_done), 32'd0);
        chk({name, ".err"}, 32'(boot_err), 32'd0);
        chk({name, ".words"}, 32'(words), 32'd0);
    endtask

    task automatic wait_end();
        for (int i = 0; i < 8000; i++) begin
            if (boot_done || boot_err) break;
            tick(1);
        end
        tick(2);
    endtask

    task automatic check_status(input string name, input bit e_done, input bit e_err, input int e_words);
        chk({name, ".done"}, 32'(boot_done), 32'(e_done));
        chk({name, ".err"}, 32'(boot_err), 32'(e_err));
        chk({name, ".hold"}, 32'(core_hold), 32'(!e_done));
        chk({name, ".words"}, 32'(words), 32'(e_words));
        chk({name, ".pending"}, 32'(exp_q.size()), 32'd0);
        $display("[TB] %s: done=%0b err=%0b words=%0d", name, boot_done, boot_err, words);
    endtask

    initial begin
        do_reset();
        check_reset("reset");

        // Two-word load, zero-wait grant, trailing bytes ignored.
        gnt = 1'b1;
        send_word(32'd2);
        push_wr(0, 32'h0020_0113);
        push_wr(1, 32'hDEAD_BEEF);
        send_word(32'h0020_0113);
        send_word(32'hDEAD_BEEF);
        wait_end();
        send_word(32'h1234_5678);
        check_status("two_words", 1'b1, 1'b0, 2);

        // Zero-length header finishes right after the 4th header byte.
        do_reset();
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        chk("zero.done_early", 32'(boot_done), 32'd0);
        send_byte(8'h00, 1'b1);
        check_status("zero_hdr", 1'b1, 1'b0, 0);

        // Header above the limit.
        do_reset();
        gnt = 1'b1;
        send_word(32'h0000_1001);
        wait_end();
        check_status("too_big", 1'b0, 1'b1, 0);

        // Delayed grant.
        do_reset();
        send_word(32'd1);
        push_wr(0, 32'hCAFE_0001);
        send_word(32'hCAFE_0001);
        tick(30 * CPB);
        chk("late_gnt.req_held", 32'(mem_if.mem_req_o), 32'd1);
        chk("late_gnt.words0", 32'(words), 32'd0);
        gnt = 1'b1;
        wait_end();
        check_status("late_gnt", 1'b1, 1'b0, 1);

        // Second word completes while the first is still ungranted.
        do_reset();
        send_word(32'd2);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        wait_end();
        chk("overflow.req", 32'(mem_if.mem_req_o), 32'd0);
        check_status("overflow", 1'b0, 1'b1, 0);

        // Bad stop bit on the 3rd data byte.
        do_reset();
        gnt = 1'b1;
        send_word(32'd2);
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h20, 1'b0);
        wait_end();
        check_status("frame_err", 1'b0, 1'b1, 0);

        // Short low glitch must not produce a byte and misalign the header.
        do_reset();
        gnt = 1'b1;
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(4 * CPB);
        send_word(32'd1);
        push_wr(0, 32'h0BAD_F00D);
        send_word(32'h0BAD_F00D);
        wait_end();
        check_status("glitch", 1'b1, 1'b0, 1);

        // Reset in the middle of the first data word.
        do_reset();
        gnt = 1'b1;
        send_word(32'd1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        do_reset();
        check_reset("mid_reset");
        gnt = 1'b1;
        send_word(32'd1);
        push_wr(0, 32'h5566_7788);
        send_word(32'h5566_7788);
        wait_end();
        check_status("after_reset", 1'b1, 1'b0, 1);

        // Randomised loads with random grant stalls.
        for (int it = 0; it < 3; it++) begin
            int          n;
            logic [31:0] w;
            n = $urandom_range(1, 3);
            do_reset();
            gnt_rand = 1'b1;
            send_word(32'(n));
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                push_wr(i, w);
                send_word(w);
            end
            wait_end();
            check_status($sformatf("random%0d", it), 1'b1, 1'b0, n);
        end

        gnt_rand = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
